// File: rtl/pipelined_memory_subsystem.sv
// rtl/pipelined_memory_subsystem.sv - dual-port on-chip memory with fixed per-port read latency
// Instruction port is read-only and wraps; data port flags out-of-range accesses.
module pipelined_memory_subsystem #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 32,
  parameter int I_ADDRESS_BITS  = 8,
  parameter int D_ADDRESS_BITS  = 12,
  parameter int I_LATENCY       = 1,
  parameter int D_LATENCY       = 2,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      i_mem_read,
  input  logic [ADDRESS_BITS-1:0]   i_mem_address_in,
  output logic [DATA_WIDTH-1:0]     i_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   i_mem_address_out,
  output logic                      i_mem_valid,
  output logic                      i_mem_ready,
  input  logic                      d_mem_read,
  input  logic                      d_mem_write,
  input  logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_out,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  output logic                      d_mem_valid,
  output logic                      d_mem_ready,
  output logic                      d_mem_error,
  input  logic                      scan
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int OFFSET    = $clog2(NUM_BYTES);
  localparam int I_IDX_W   = I_ADDRESS_BITS - OFFSET;
  localparam int D_IDX_W   = D_ADDRESS_BITS - OFFSET;
  localparam int I_WORDS   = 2 ** I_IDX_W;
  localparam int D_WORDS   = 2 ** D_IDX_W;

  // Arrays carry no reset so contents survive a reset pulse.
  logic [DATA_WIDTH-1:0] i_mem_q [I_WORDS];
  logic [DATA_WIDTH-1:0] d_mem_q [D_WORDS];

  logic i_ready_q, d_ready_q;
  logic [31:0] cycle_q;

  logic [DATA_WIDTH-1:0]   i_dat_q [I_LATENCY];
  logic [ADDRESS_BITS-1:0] i_adr_q [I_LATENCY];
  logic [I_LATENCY-1:0]    i_vld_q;
  logic [DATA_WIDTH-1:0]   d_dat_q [D_LATENCY];
  logic [ADDRESS_BITS-1:0] d_adr_q [D_LATENCY];
  logic [D_LATENCY-1:0]    d_vld_q;
  logic [D_LATENCY-1:0]    d_err_q;

  logic [I_IDX_W-1:0] i_idx;
  logic [D_IDX_W-1:0] d_idx;
  logic i_rd_acc, d_rd_acc, d_wr_acc, d_oor;

  assign i_idx    = i_mem_address_in[I_ADDRESS_BITS-1:OFFSET];
  assign d_idx    = d_mem_address_in[D_ADDRESS_BITS-1:OFFSET];
  assign d_oor    = (d_mem_address_in >> D_ADDRESS_BITS) != '0;
  assign i_rd_acc = i_mem_read & i_ready_q;
  assign d_rd_acc = d_mem_read & d_ready_q;
  assign d_wr_acc = d_mem_write & d_ready_q & ~d_oor;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      cycle_q   <= '0;
    end else begin
      i_ready_q <= 1'b1;
      d_ready_q <= 1'b1;
      cycle_q   <= cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (d_wr_acc) begin
      for (int b = 0; b < NUM_BYTES; b++) begin
        if (d_mem_byte_en[b]) d_mem_q[d_idx][b*8 +: 8] <= d_mem_data_in[b*8 +: 8];
      end
    end
  end

  // Stage 0 is the synchronous array read; later stages hold data when idle
  // so the outputs keep their last valid values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_vld_q <= '0;
      for (int s = 0; s < I_LATENCY; s++) begin
        i_dat_q[s] <= '0;
        i_adr_q[s] <= '0;
      end
    end else begin
      i_vld_q[0] <= i_rd_acc;
      if (i_rd_acc) begin
        i_dat_q[0] <= i_mem_q[i_idx];
        i_adr_q[0] <= i_mem_address_in;
      end
      for (int s = 1; s < I_LATENCY; s++) begin
        i_vld_q[s] <= i_vld_q[s-1];
        if (i_vld_q[s-1]) begin
          i_dat_q[s] <= i_dat_q[s-1];
          i_adr_q[s] <= i_adr_q[s-1];
        end
      end
    end
  end

  // Reading the array before the same-edge write lands gives read-old-data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_vld_q <= '0;
      d_err_q <= '0;
      for (int s = 0; s < D_LATENCY; s++) begin
        d_dat_q[s] <= '0;
        d_adr_q[s] <= '0;
      end
    end else begin
      d_vld_q[0] <= d_rd_acc;
      if (d_rd_acc) begin
        d_err_q[0] <= d_oor;
        d_dat_q[0] <= d_oor ? '0 : d_mem_q[d_idx];
        d_adr_q[0] <= d_mem_address_in;
      end
      for (int s = 1; s < D_LATENCY; s++) begin
        d_vld_q[s] <= d_vld_q[s-1];
        if (d_vld_q[s-1]) begin
          d_err_q[s] <= d_err_q[s-1];
          d_dat_q[s] <= d_dat_q[s-1];
          d_adr_q[s] <= d_adr_q[s-1];
        end
      end
    end
  end

  assign i_mem_ready       = i_ready_q;
  assign i_mem_valid       = i_vld_q[I_LATENCY-1];
  assign i_mem_data_out    = i_dat_q[I_LATENCY-1];
  assign i_mem_address_out = i_adr_q[I_LATENCY-1];
  assign d_mem_ready       = d_ready_q;
  assign d_mem_valid       = d_vld_q[D_LATENCY-1];
  assign d_mem_error       = d_vld_q[D_LATENCY-1] & d_err_q[D_LATENCY-1];
  assign d_mem_data_out    = d_dat_q[D_LATENCY-1];
  assign d_mem_address_out = d_adr_q[D_LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset && scan && cycle_q >= 32'(SCAN_CYCLES_MIN) && cycle_q <= 32'(SCAN_CYCLES_MAX)) begin
      if (i_rd_acc)
        $display("core %0d cycle %0d ifetch addr %h", CORE, cycle_q, i_mem_address_in);
      if ((d_mem_read | d_mem_write) & d_ready_q)
        $display("core %0d cycle %0d dmem rd %0d wr %0d be %b addr %h wdata %h", CORE, cycle_q,
                 d_mem_read, d_mem_write, d_mem_byte_en, d_mem_address_in, d_mem_data_in);
    end
  end

endmodule

// File: tb/tb_pipelined_memory_subsystem.sv
// tb/tb_pipelined_memory_subsystem.sv - scoreboard bench for pipelined_memory_subsystem
module tb_pipelined_memory_subsystem;
  localparam int IL = 2;
  localparam int DL = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_mem_read = 1'b0;
  logic [31:0] i_mem_address_in = '0;
  logic [31:0] i_mem_data_out, i_mem_address_out;
  logic        i_mem_valid, i_mem_ready;
  logic        d_mem_read = 1'b0, d_mem_write = 1'b0;
  logic [3:0]  d_mem_byte_en = '0;
  logic [31:0] d_mem_address_in = '0, d_mem_data_in = '0;
  logic [31:0] d_mem_data_out, d_mem_address_out;
  logic        d_mem_valid, d_mem_ready, d_mem_error;
  logic        scan = 1'b0;

  pipelined_memory_subsystem #(
    .CORE(3), .DATA_WIDTH(32), .ADDRESS_BITS(32), .I_ADDRESS_BITS(8), .D_ADDRESS_BITS(12),
    .I_LATENCY(IL), .D_LATENCY(DL), .SCAN_CYCLES_MIN(0), .SCAN_CYCLES_MAX(1000)
  ) dut (
    .clock(clock), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_address_in(i_mem_address_in),
    .i_mem_data_out(i_mem_data_out), .i_mem_address_out(i_mem_address_out),
    .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_byte_en(d_mem_byte_en),
    .d_mem_address_in(d_mem_address_in), .d_mem_data_in(d_mem_data_in),
    .d_mem_data_out(d_mem_data_out), .d_mem_address_out(d_mem_address_out),
    .d_mem_valid(d_mem_valid), .d_mem_ready(d_mem_ready), .d_mem_error(d_mem_error),
    .scan(scan)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        err;
    int          when;
  } rsp_t;

  rsp_t d_q[$];
  rsp_t i_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clock) begin
    rsp_t e;
    if (reset && d_mem_valid) begin
      if (d_q.size() == 0) check("d_unexpected_valid", {d_mem_address_out, d_mem_data_out}, 0);
      else begin
        e = d_q.pop_front();
        check("d_rsp", {d_mem_error, d_mem_address_out, d_mem_data_out}, {e.err, e.addr, e.data});
        check("d_latency", cyc, e.when);
      end
    end
  end

  always @(negedge clock) begin
    rsp_t e;
    if (reset && i_mem_valid) begin
      if (i_q.size() == 0) check("i_unexpected_valid", {i_mem_address_out, i_mem_data_out}, 0);
      else begin
        e = i_q.pop_front();
        check("i_rsp", {i_mem_address_out, i_mem_data_out}, {e.addr, e.data});
        check("i_latency", cyc, e.when);
      end
    end
  end

  // Called just after a rising edge; the request is accepted at the next one.
  task automatic d_op(input logic rd, input logic wr, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp, input logic err);
    d_mem_read = rd;
    d_mem_write = wr;
    d_mem_byte_en = be;
    d_mem_address_in = addr;
    d_mem_data_in = wdata;
    if (rd) d_q.push_back('{exp, addr, err, cyc + DL});
    @(posedge clock); #1;
  endtask

  task automatic d_idle();
    d_mem_read = 1'b0;
    d_mem_write = 1'b0;
  endtask

  task automatic i_op(input logic [31:0] addr, input logic [31:0] exp);
    i_mem_read = 1'b1;
    i_mem_address_in = addr;
    i_q.push_back('{exp, addr, 1'b0, cyc + IL});
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int pulses;
    int waited;
    for (int k = 0; k < 64; k++) dut.i_mem_q[k] = 32'hA000_0000 + k;

    #2;
    check("reset_ctrl", {i_mem_valid, d_mem_valid, d_mem_error, i_mem_ready, d_mem_ready}, 0);
    check("reset_data", {i_mem_data_out, d_mem_data_out, i_mem_address_out, d_mem_address_out}, 0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    #1 check("ready_release_cycle", {i_mem_ready, d_mem_ready}, 2'b00);
    @(posedge clock); #1;
    check("ready_after_edge", {i_mem_ready, d_mem_ready}, 2'b11);
    check("valid_idle", {i_mem_valid, d_mem_valid}, 2'b00);

    d_op(0, 1, 4'hF, 32'h010, 32'hDEADBEEF, 0, 0);
    d_op(1, 0, 4'h0, 32'h010, 0, 32'hDEADBEEF, 0);
    d_op(0, 1, 4'hF, 32'h020, 32'h11223344, 0, 0);
    d_op(0, 1, 4'h5, 32'h020, 32'hAABBCCDD, 0, 0);
    d_op(1, 0, 4'h0, 32'h020, 0, 32'h11BB33DD, 0);
    d_op(0, 1, 4'hF, 32'h030, 32'h0, 0, 0);
    d_op(1, 1, 4'hF, 32'h030, 32'h55, 32'h0, 0);
    d_op(1, 0, 4'h0, 32'h030, 0, 32'h55, 0);
    d_op(0, 1, 4'hF, 32'h000, 32'hCAFEF00D, 0, 0);
    d_op(1, 0, 4'h0, 32'h1000, 0, 32'h0, 1);
    d_op(0, 1, 4'hF, 32'h1000, 32'h12345678, 0, 0);
    d_op(1, 0, 4'h0, 32'h000, 0, 32'hCAFEF00D, 0);
    d_op(1, 0, 4'h0, 32'h8000_0000, 0, 32'h0, 1);
    d_op(0, 1, 4'hF, 32'hFFC, 32'h0BADF00D, 0, 0);
    d_op(1, 0, 4'h0, 32'hFFE, 0, 32'h0BADF00D, 0);
    d_idle();
    repeat (5) @(posedge clock); #1;

    scan = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) i_op(32'(4 * k), 32'hA000_0000 + 32'(k));
        i_op(32'h0000_0105, 32'hA000_0001);
        i_mem_read = 1'b0;
      end
      begin
        d_op(1, 0, 4'h0, 32'h010, 0, 32'hDEADBEEF, 0);
        d_op(1, 0, 4'h0, 32'h020, 0, 32'h11BB33DD, 0);
        d_op(1, 0, 4'h0, 32'h030, 0, 32'h55, 0);
        d_idle();
      end
    join
    scan = 1'b0;
    repeat (6) @(posedge clock); #1;

    d_mem_read = 1'b1;
    d_mem_address_in = 32'h010;
    @(posedge clock); #1;
    d_mem_address_in = 32'h020;
    @(posedge clock); #1;
    d_mem_read = 1'b0;
    reset = 1'b0;
    pulses = 0;
    repeat (2) begin @(negedge clock); pulses += int'(d_mem_valid); end
    reset = 1'b1;
    repeat (5) begin @(negedge clock); pulses += int'(d_mem_valid); end
    check("abort_no_valid", pulses, 0);
    @(posedge clock); #1;
    check("ready_after_reset", {i_mem_ready, d_mem_ready}, 2'b11);

    d_op(1, 0, 4'h0, 32'h010, 0, 32'hDEADBEEF, 0);
    d_op(1, 0, 4'h0, 32'h020, 0, 32'h11BB33DD, 0);
    d_idle();

    waited = 0;
    while ((d_q.size() != 0 || i_q.size() != 0) && waited < 20) begin
      @(posedge clock);
      waited++;
    end
    repeat (2) @(posedge clock);
    check("d_queue_drained", d_q.size(), 0);
    check("i_queue_drained", i_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
